// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared widths, memory op encoding and FSM states for the LSU
package load_store_unit_pkg;
   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 64;
   localparam int BYTE_SEL_W = 3;
   typedef enum logic [1:0] {LD, SD, LB, SB} mem_op_t;
   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: byte extract (zero-extended) and byte merge on one word; lane 0 is the most significant byte
import load_store_unit_pkg::*;
module lsu_byte_lane (
   input  logic [DATA_W-1:0]     word,
   input  logic [BYTE_SEL_W-1:0] lane,
   input  logic [7:0]            new_byte,
   output logic [DATA_W-1:0]     extracted,
   output logic [DATA_W-1:0]     merged
);
   logic [5:0] sh;
   // lane k sits 8*(7-k) bits above the LSB, and ~lane equals 7-lane
   always_comb begin
      sh = {~lane, 3'b000};
      extracted = (word >> sh) & 64'hFF;
      merged = (word & ~(64'hFF << sh)) | ({56'b0, new_byte} << sh);
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store FSM driving a one-cycle-latency memory array
import load_store_unit_pkg::*;
module load_store_unit (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  mem_op_t               req_op,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [BYTE_SEL_W-1:0] req_byte,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_W-1:0]     resp_data,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_we,
   input  logic [DATA_W-1:0]     mem_rdata
);
   lsu_state_t state;
   mem_op_t op_q;
   logic [BYTE_SEL_W-1:0] lane_q;
   logic [7:0] byte_q;
   logic [DATA_W-1:0] extracted, merged;

   lsu_byte_lane u_lane (
      .word(mem_rdata),
      .lane(lane_q),
      .new_byte(byte_q),
      .extracted(extracted),
      .merged(merged)
   );

   assign req_ready = state == IDLE;

   // request sequencing: SD writes directly, SB reads-modifies-writes, loads capture read data
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         resp_valid <= 1'b0;
         resp_data <= '0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               mem_addr <= req_addr;
               op_q <= req_op;
               lane_q <= req_byte;
               byte_q <= req_wdata[7:0];
               mem_we <= req_op == SD;
               if (req_op == SD) mem_wdata <= req_wdata;
               state <= req_op == SD ? WR : RD;
            end
            RD: state <= CAP;
            CAP: if (op_q == SB) begin
               mem_wdata <= merged;
               mem_we <= 1'b1;
               state <= WR;
            end else begin
               resp_data <= op_q == LB ? extracted : mem_rdata;
               resp_valid <= 1'b1;
               state <= RESP;
            end
            WR: begin
               mem_we <= 1'b0;
               resp_data <= '0;
               resp_valid <= 1'b1;
               state <= RESP;
            end
            RESP: if (resp_ready) begin
               resp_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL expose the following ports; one clock; reset is synchronous and active-high:
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  pipeline request present.
REQ-005 req_ready  out  1  LSU can accept a request this cycle.
REQ-006 req_op  in  mem_op_t (2)  LD (load word), SD (store word), LB (load byte), SB (store byte).
REQ-007 req_addr  in  8  word address.
REQ-008 req_byte  in  3  byte lane for LB/SB; lane 0 = data bits [0:7], lane 7 = bits [56:63].
REQ-009 req_wdata  in  64  store data; SB uses bits [56:63] only.
REQ-010 resp_valid  out  1  response pending.
REQ-011 resp_ready  in  1  pipeline consumes response.
REQ-012 resp_data  out  64  load result; LB zero-extended into [56:63]; 0 for stores.
REQ-013 mem_addr  out  8  registered word address to the memory array.
REQ-014 mem_wdata  out  64  registered write data to the memory array.
REQ-015 mem_we  out  1  registered write enable to the memory array.
REQ-016 mem_rdata  in  64  memory read data; valid one cycle after mem_addr is sampled.

Function
REQ-017 FSM states SHALL be IDLE, RD, CAP, WR, RESP; one request in flight at a time.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid && req_ready.
REQ-019 On acceptance: mem_addr <= req_addr, and the op, lane and wdata are latched.
REQ-020 On acceptance of SD: mem_wdata <= req_wdata and mem_we <= 1, then next state WR.
REQ-021 On acceptance of LD, LB or SB: mem_we <= 0, then next state RD.
REQ-022 RD SHALL last one cycle (the array samples mem_addr), then go to CAP.
REQ-023 CAP for LD/LB: resp_data <= mem_rdata (LB: selected byte, zero-extended); resp_valid <= 1; next state RESP; resp_valid rises 2 cycles after acceptance.
REQ-024 CAP for SB: mem_wdata <= mem_rdata with the selected lane replaced by req_wdata[56:63], other lanes unchanged; mem_we <= 1; next state WR.
REQ-025 WR SHALL last one cycle (write commits at its closing edge); then mem_we <= 0, resp_data <= 0, resp_valid <= 1, next state RESP.
REQ-026 Store latency to resp_valid SHALL be 1 cycle for SD and 3 cycles for SB.
REQ-027 In RESP, resp_valid and resp_data SHALL hold stable until resp_ready=1 at a clock edge; the FSM then clears resp_valid and goes to IDLE.
REQ-028 A new request SHALL NOT be accepted in the same cycle as the response handshake; back-to-back requests are spaced by at least one IDLE cycle.
REQ-029 mem_we SHALL be high for exactly one cycle per store and never for loads.
REQ-030 An LB or SB to lane 7 and an access to address 255 SHALL behave as any other lane or address; there is no wrap or overflow logic.

Reset
REQ-031 When rst=1 at a rising edge: state=IDLE, resp_valid=0, resp_data=0, mem_we=0, mem_addr=0, mem_wdata=0; req_ready is 1 in the cycle after reset deasserts.
REQ-032 Reset mid-operation SHALL drop the in-flight request with no response.
REQ-033 A write whose mem_we was already high in the reset cycle commits in the array; no further write is issued.

Structure
REQ-034 mem_op_t, ADDR_W=8, DATA_W=64 and BYTE_SEL_W=3 SHALL live in the shared header package.
REQ-035 Byte merge and extract SHALL be one combinational sub-module, lsu_byte_lane, reused for LB extract and SB merge.

Verification
REQ-036 Reset, then SD addr 0x10 data 0x0123456789ABCDEF -> mem_we high for one cycle; resp_valid the next cycle with resp_data=0.
REQ-037 LD addr 0x10 after REQ-036 -> resp_valid 2 cycles after acceptance with resp_data=0x0123456789ABCDEF.
REQ-038 SB addr 0x10 lane 3 wdata[56:63]=0xFF, then LD 0x10 -> 0x012345FF89ABCDEF; SB resp 3 cycles after acceptance.
REQ-039 LB addr 0x10 lane 7 -> resp_data=0x00000000000000EF; hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0 throughout.
REQ-040 Assert rst during the SB RD state -> no response, mem_we never rises; LD 0x10 afterwards returns the unmodified word.
